// File: rtl/mem_seq_pkg.sv
// Shared encodings for the board-memory sequencer: FSM states, address width
// and the memory's write-pattern select codes.
package mem_seq_pkg;

  localparam int unsigned ADDR_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Pattern select codes understood by the memory block's write path
  localparam logic [1:0] PAT_12345678 = 2'd0;
  localparam logic [1:0] PAT_87654321 = 2'd1;
  localparam logic [1:0] PAT_FFFFFFFF = 2'd2;
  localparam logic [1:0] PAT_00011000 = 2'd3;

  // Write pattern rotates with the low address bits
  function automatic logic [1:0] pat_sel(input logic [1:0] addr_lo);
    logic [1:0] pat;
    case (addr_lo)
      2'd0:    pat = PAT_12345678;
      2'd1:    pat = PAT_87654321;
      2'd2:    pat = PAT_FFFFFFFF;
      default: pat = PAT_00011000;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-flop synchroniser, stable-level debounce over
// DEB_CYC samples, and a one-cycle pulse on each accepted rising level.
module btn_debounce #(
  parameter int unsigned DEB_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  localparam int unsigned CNT_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

  logic             sync_a;
  logic             sync_b;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // cnt tracks how long the synchronised input has disagreed with the accepted level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      level  <= 1'b0;
      cnt    <= '0;
      pulse  <= 1'b0;
    end else begin
      sync_a <= btn;
      sync_b <= sync_a;
      pulse  <= 1'b0;
      if (sync_b == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEB_CYC - 1)) begin
        cnt   <= '0;
        level <= sync_b;
        pulse <= sync_b;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mem_seq_ctrl.sv
// Board-memory sequencer: on a debounced start press, writes every word with its
// pattern, then presents each word byte by byte for DWELL cycles.
// Build option MEM_SEQ_MANUAL_STEP_EN: read bytes advance on debounced step_btn presses.
module mem_seq_ctrl
  import mem_seq_pkg::*;
#(
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned DWELL   = 50_000_000,
  parameter int unsigned DEB_CYC = 1_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_btn,
  input  logic              step_btn,
  output logic [ADDR_W-1:0] mem_arr,
  output logic [1:0]        sw,
  output logic              mem_write,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic [1:0]        byte_sel, byte_n;
  logic              start_p;
  logic              advance;

  logic [ADDR_W-1:0] mem_arr_n;
  logic [1:0]        sw_n;
  logic              mem_write_n;
  logic              busy_n;
  logic              done_n;

  btn_debounce #(.DEB_CYC(DEB_CYC)) u_start (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (start_btn),
    .pulse (start_p)
  );

`ifdef MEM_SEQ_MANUAL_STEP_EN
  logic step_p;

  btn_debounce #(.DEB_CYC(DEB_CYC)) u_step (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (step_btn),
    .pulse (step_p)
  );

  assign advance = step_p;
`else
  localparam int unsigned DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic [DW_W-1:0] dwell, dwell_n;
  logic            step_unused;

  assign step_unused = step_btn;
  assign advance     = (dwell == DW_W'(DWELL - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dwell <= '0;
    else        dwell <= dwell_n;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      addr      <= '0;
      byte_sel  <= '0;
      mem_arr   <= '0;
      sw        <= '0;
      mem_write <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      addr      <= addr_n;
      byte_sel  <= byte_n;
      mem_arr   <= mem_arr_n;
      sw        <= sw_n;
      mem_write <= mem_write_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

  // Next state, then outputs decoded from the next state so they align with it
  always_comb begin
    state_n     = state;
    addr_n      = addr;
    byte_n      = byte_sel;
`ifndef MEM_SEQ_MANUAL_STEP_EN
    dwell_n     = dwell;
`endif
    mem_arr_n   = '0;
    sw_n        = '0;
    mem_write_n = 1'b0;
    busy_n      = 1'b0;
    done_n      = 1'b0;

    case (state)
      ST_IDLE, ST_DONE: begin
        if (start_p) begin
          state_n = ST_WR;
          addr_n  = '0;
          byte_n  = '0;
        end
      end
      ST_WR: begin
        if (addr == LAST_ADDR) begin
          state_n = ST_RD;
          addr_n  = '0;
          byte_n  = '0;
`ifndef MEM_SEQ_MANUAL_STEP_EN
          dwell_n = '0;
`endif
        end else begin
          addr_n = addr + ADDR_W'(1);
        end
      end
      ST_RD: begin
`ifndef MEM_SEQ_MANUAL_STEP_EN
        dwell_n = advance ? '0 : dwell + DW_W'(1);
`endif
        if (advance) begin
          if (byte_sel == 2'd3) begin
            if (addr == LAST_ADDR) begin
              state_n = ST_DONE;
            end else begin
              addr_n = addr + ADDR_W'(1);
              byte_n = 2'd0;
            end
          end else begin
            byte_n = byte_sel + 2'd1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    case (state_n)
      ST_WR: begin
        mem_arr_n   = addr_n;
        sw_n        = pat_sel(addr_n[1:0]);
        mem_write_n = 1'b1;
        busy_n      = 1'b1;
      end
      ST_RD: begin
        mem_arr_n = addr_n;
        sw_n      = byte_n;
        busy_n    = 1'b1;
      end
      ST_DONE: begin
        mem_arr_n = addr_n;
        sw_n      = byte_n;
        done_n    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_seq_ctrl.sv
// Bench for mem_seq_ctrl (default build): randomised bouncy presses checked every
// cycle against a run-timeline model, plus literal checks on key run figures.
module tb_mem_seq_ctrl;

  localparam int DEPTH   = 4;
  localparam int DWELL   = 3;
  localparam int DEB     = 4;
  localparam int RUN_LEN = 52;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_btn;
  logic       step_btn;
  logic [5:0] mem_arr;
  logic [1:0] sw;
  logic       mem_write;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_errors = 0;

  int wr_arr[4];
  int wr_sw[4];

  mem_seq_ctrl #(.DEPTH(DEPTH), .DWELL(DWELL), .DEB_CYC(DEB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_btn (start_btn),
    .step_btn  (step_btn),
    .mem_arr   (mem_arr),
    .sw        (sw),
    .mem_write (mem_write),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp_v);
    n_checks++;
    if (got != exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp_v, $time);
    end
  endtask

  // Model: the button is accepted once DEB consecutive synchronised samples agree on
  // a new level; a run is a timeline t = 0..RUN_LEN-1 starting the cycle after acceptance.
  int   m_phase = 0;
  int   m_t     = 0;
  int   m_run   = 0;
  logic m_s1 = 1'b0, m_s2 = 1'b0, m_acc = 1'b0, m_last = 1'b0, m_pulse = 1'b0;

  initial begin
    logic x;
    int   r;
    int   e_arr, e_sw, e_mw, e_busy, e_done;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_phase = 0; m_t = 0; m_run = 0;
        m_s1 = 1'b0; m_s2 = 1'b0; m_acc = 1'b0; m_last = 1'b0; m_pulse = 1'b0;
      end else begin
        if (m_phase == 1) begin
          m_t++;
          if (m_t == DEPTH + DEPTH * 4 * DWELL) m_phase = 2;
        end else if (m_pulse) begin
          m_phase = 1;
          m_t     = 0;
        end
        x    = m_s2;
        m_s2 = m_s1;
        m_s1 = start_btn;
        if (x == m_last) m_run++;
        else begin
          m_run  = 1;
          m_last = x;
        end
        m_pulse = 1'b0;
        if (m_run >= DEB && x != m_acc) begin
          m_acc   = x;
          m_pulse = x;
        end
      end
      e_arr = 0; e_sw = 0; e_mw = 0; e_busy = 0; e_done = 0;
      if (m_phase == 1) begin
        e_busy = 1;
        if (m_t < DEPTH) begin
          e_mw  = 1;
          e_arr = m_t;
          e_sw  = m_t % 4;
        end else begin
          r     = m_t - DEPTH;
          e_arr = r / (4 * DWELL);
          e_sw  = (r / DWELL) % 4;
        end
      end else if (m_phase == 2) begin
        e_arr  = DEPTH - 1;
        e_sw   = 3;
        e_done = 1;
      end
      #1;
      n_checks++;
      if (int'(mem_arr) != e_arr || int'(sw) != e_sw || int'(mem_write) != e_mw ||
          int'(busy) != e_busy || int'(done) != e_done) begin
        n_errors++;
        $display("FAIL cycle_cmp t=%0t: got arr=%0d sw=%0d mw=%0d busy=%0d done=%0d, expected arr=%0d sw=%0d mw=%0d busy=%0d done=%0d",
                 $time, mem_arr, sw, mem_write, busy, done, e_arr, e_sw, e_mw, e_busy, e_done);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Press with bounces on both edges; every bounce segment is shorter than DEB
  task automatic press(input int bounces);
    start_btn = 1'b0;
    for (int i = 0; i < bounces; i++) begin
      start_btn = ~start_btn;
      cycles($urandom_range(1, DEB - 1));
    end
    start_btn = 1'b1;
    cycles($urandom_range(DEB + 2, DEB + 10));
    for (int i = 0; i < bounces; i++) begin
      start_btn = ~start_btn;
      cycles($urandom_range(1, DEB - 1));
    end
    start_btn = 1'b0;
  endtask

  task automatic clean_press();
    press(0);
  endtask

  // Waits for a run to start, then counts busy and write cycles until it ends
  task automatic measure(input int inject, output int nbusy, output int nwr);
    int guard = 0;
    nbusy = 0;
    nwr   = 0;
    @(posedge clk); #1;
    while (!busy && guard < 300) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("start_seen", int'(busy), 1);
    chk("start_edge_done_mw", int'({done, mem_write}), 1);
    guard = 0;
    while (busy && guard < 400) begin
      nbusy++;
      if (mem_write) begin
        if (nwr < 4) begin
          wr_arr[nwr] = int'(mem_arr);
          wr_sw[nwr]  = int'(sw);
        end
        nwr++;
      end
      if (nbusy == inject) fork clean_press(); join_none
      @(posedge clk); #1;
      guard++;
    end
    chk("run_ended", int'(busy), 0);
  endtask

  initial begin
    int nb, nw, mw_seen;
    rst_n     = 1'b1;
    start_btn = 1'b0;
    step_btn  = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_outs", int'({mem_arr, sw, mem_write, busy, done}), 0);
    cycles(3);
    rst_n = 1'b1;
    cycles(5);

    // Bouncy start, five short toggles before the hold
    fork
      press(5);
      measure(-1, nb, nw);
    join
    chk("run1_busy_cycles", nb, RUN_LEN);
    chk("run1_write_cycles", nw, 4);
    for (int i = 0; i < 4; i++) begin
      chk("wr_addr", wr_arr[i], i);
      chk("wr_pattern", wr_sw[i], i);
    end
    chk("run1_done", int'(done), 1);
    chk("run1_final_arr", int'(mem_arr), 3);
    chk("run1_final_sw", int'(sw), 3);
    chk("model_phase_done", m_phase, 2);
    cycles(2 * DEB + 6);

    // Restart from DONE with a second press landing in the read phase
    fork
      clean_press();
      measure(20, nb, nw);
    join
    chk("run2_busy_cycles", nb, RUN_LEN);
    chk("run2_write_cycles", nw, 4);
    chk("run2_done", int'(done), 1);
    cycles(2 * DEB + 20);
    chk("no_restart_from_rd_press", int'(done), 1);

    // Reset in the middle of the read phase
    clean_press();
    cycles($urandom_range(8, 25));
    chk("in_read_phase", int'({busy, mem_write}), 2);
    rst_n = 1'b0;
    #1;
    chk("midrun_reset_outs", int'({mem_arr, sw, mem_write, busy, done}), 0);
    cycles(3);
    rst_n   = 1'b1;
    mw_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (mem_write || busy) mw_seen++;
    end
    chk("no_activity_after_reset", mw_seen, 0);

    // Randomised presses
    for (int k = 0; k < 4; k++) begin
      cycles($urandom_range(2 * DEB + 4, 2 * DEB + 30));
      fork
        press($urandom_range(0, 5));
        measure($urandom_range(5, 45), nb, nw);
      join
      chk("rand_busy_cycles", nb, RUN_LEN);
      chk("rand_write_cycles", nw, 4);
      chk("rand_done", int'(done), 1);
      cycles(2 * DEB + 20);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
